// File: rtl/mult_div_unit_if.sv
// Handshake/operand bundle between the ALU control decoder and mult_div_unit.
interface mult_div_unit_if #(parameter int WIDTH = 32);
  logic             multOp;
  logic             divOp;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             divZero;

  modport master (output multOp, divOp, a, b, input hi, lo, busy, done, divZero);
  modport slave  (input multOp, divOp, a, b, output hi, lo, busy, done, divZero);
endinterface

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring) producing HI/LO.
// Optional macro MULT_DIV_ZERO_SHORTCUT_EN: multiplies with a zero operand finish without iterating.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  mult_div_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   acc_q, acc_d;     // Booth upper half / restoring remainder
  logic [WIDTH-1:0] qr_q, qr_d;       // multiplier / dividend-quotient shift register
  logic [WIDTH-1:0] m_q, m_d;         // multiplicand / divisor magnitude
  logic             qm1_q, qm1_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d, done_q, done_d, dz_q, dz_d;

  // Booth step: add/sub multiplicand, then arithmetic shift of {acc, qr, qm1}.
  logic [WIDTH:0]   m_ext, booth_sum, booth_acc;
  logic [WIDTH-1:0] booth_qr;
  // Restoring step: shift one dividend bit into the remainder, trial-subtract.
  logic [WIDTH:0]   div_shift, div_diff, div_rem;
  logic [WIDTH-1:0] div_qr, div_q_fin, div_r_fin, a_abs, b_abs;

  always_comb begin
    m_ext = {m_q[WIDTH-1], m_q};
    unique case ({qr_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + m_ext;
      2'b10:   booth_sum = acc_q - m_ext;
      default: booth_sum = acc_q;
    endcase
    booth_acc = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    booth_qr  = {booth_sum[0], qr_q[WIDTH-1:1]};

    div_shift = {acc_q[WIDTH-1:0], qr_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, m_q};
    div_rem   = div_diff[WIDTH] ? div_shift : div_diff;
    div_qr    = {qr_q[WIDTH-2:0], ~div_diff[WIDTH]};
    div_q_fin = qneg_q ? (~div_qr + 1'b1) : div_qr;
    div_r_fin = rneg_q ? (~div_rem[WIDTH-1:0] + 1'b1) : div_rem[WIDTH-1:0];

    a_abs = bus.a[WIDTH-1] ? (~bus.a + 1'b1) : bus.a;
    b_abs = bus.b[WIDTH-1] ? (~bus.b + 1'b1) : bus.b;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    qr_d    = qr_q;
    m_d     = m_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.multOp) begin
          dz_d  = 1'b0;
          acc_d = '0;
          qr_d  = bus.b;
          m_d   = bus.a;
          qm1_d = 1'b0;
          cnt_d = '0;
`ifdef MULT_DIV_ZERO_SHORTCUT_EN
          if (bus.a == '0 || bus.b == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            hi_d    = '0;
            lo_d    = '0;
          end else begin
            state_d = S_MULT;
            busy_d  = 1'b1;
          end
`else
          state_d = S_MULT;
          busy_d  = 1'b1;
`endif
        end else if (bus.divOp) begin
          cnt_d = '0;
          if (bus.b == '0) begin
            dz_d    = 1'b1;
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            dz_d    = 1'b0;
            acc_d   = '0;
            qr_d    = a_abs;
            m_d     = b_abs;
            qneg_d  = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            rneg_d  = bus.a[WIDTH-1];
            state_d = S_DIV;
            busy_d  = 1'b1;
          end
        end
      end
      S_MULT: begin
        acc_d = booth_acc;
        qr_d  = booth_qr;
        qm1_d = qr_q[0];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          hi_d    = booth_acc[WIDTH-1:0];
          lo_d    = booth_qr;
        end else begin
          busy_d = 1'b1;
        end
      end
      S_DIV: begin
        acc_d = div_rem;
        qr_d  = div_qr;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          hi_d    = div_r_fin;
          lo_d    = div_q_fin;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      qr_q    <= '0;
      m_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      qr_q    <= qr_d;
      m_q     <= m_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.divZero = dz_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: cycle-level reference model plus directed and random operations.
module tb_mult_div_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mult_div_unit_if #(.WIDTH(W)) bus ();
  mult_div_unit #(.WIDTH(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: idle / running (cycles left) / done, results from plain arithmetic.
  int          m_phase;   // 0 idle, 1 running, 2 done
  int          m_left;
  logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
  logic         m_dz;

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    return p;
  endfunction

  function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] x, input logic [W-1:0] y);
    int sx, sy, q, r;
    logic [W-1:0] qu;
    sx = $signed(x);
    sy = $signed(y);
    if (sy == -1) begin
      qu = 32'd0 - x;
      return {32'd0, qu};
    end
    q = sx / sy;
    r = sx % sy;
    return {r, q};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase = 0; m_left = 0; m_hi = '0; m_lo = '0; m_dz = 1'b0;
    end else begin
      case (m_phase)
        0: begin
          if (bus.multOp) begin
            m_dz = 1'b0;
            {p_hi, p_lo} = ref_mul(bus.a, bus.b);
`ifdef MULT_DIV_ZERO_SHORTCUT_EN
            if (bus.a == 0 || bus.b == 0) begin
              m_phase = 2; m_hi = '0; m_lo = '0;
            end else begin
              m_phase = 1; m_left = W;
            end
`else
            m_phase = 1; m_left = W;
`endif
          end else if (bus.divOp) begin
            if (bus.b == 0) begin
              m_dz = 1'b1; m_phase = 2;
            end else begin
              m_dz = 1'b0;
              {p_hi, p_lo} = ref_div(bus.a, bus.b);
              m_phase = 1; m_left = W;
            end
          end
        end
        1: begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            m_phase = 2; m_hi = p_hi; m_lo = p_lo;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic [2*W+2:0] act, exp_v;
    act   = {bus.hi, bus.lo, bus.busy, bus.done, bus.divZero};
    exp_v = {m_hi, m_lo, m_phase == 1, m_phase == 2, m_dz};
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL cycle_model t=%0t got hi=%h lo=%h busy=%b done=%b dz=%b want hi=%h lo=%h busy=%b done=%b dz=%b",
               $time, bus.hi, bus.lo, bus.busy, bus.done, bus.divZero,
               m_hi, m_lo, m_phase == 1, m_phase == 2, m_dz);
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s got %h want %h", name, act, exp_v);
    end
  endtask

  // Issue one start; observe 40 cycles (negedge index 0 is the cycle after the start edge).
  task automatic run_op(input logic mo, input logic dv, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input int inj_at, output int busy_n, output int done_n, output int done_at);
    busy_n = 0; done_n = 0; done_at = -1;
    @(negedge clk);
    bus.multOp = mo; bus.divOp = dv; bus.a = av; bus.b = bv;
    @(negedge clk);
    bus.multOp = 1'b0; bus.divOp = 1'b0;
    bus.a = $urandom; bus.b = $urandom;
    for (int i = 0; i < W + 8; i++) begin
      if (bus.busy) busy_n++;
      if (bus.done) begin done_n++; if (done_at < 0) done_at = i; end
      bus.divOp = (i == inj_at);
      @(negedge clk);
    end
    bus.divOp = 1'b0;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20)) - 32'd10;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int bn, dn, da;
    logic [W-1:0] ra, rb;
    bus.multOp = 1'b0; bus.divOp = 1'b0; bus.a = '0; bus.b = '0;

    // Reset held with a start strobe present.
    bus.multOp = 1'b1; bus.a = 32'd9; bus.b = 32'd9;
    repeat (3) @(negedge clk);
    chk("reset_hi", bus.hi, 32'h0);
    chk("reset_lo", bus.lo, 32'h0);
    chk("reset_flags", {29'd0, bus.busy, bus.done, bus.divZero}, 32'h0);
    bus.multOp = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    chk("reset_no_start", {31'd0, bus.busy}, 32'h0);

    // Multiply -7 * 6
    run_op(1, 0, 32'hFFFF_FFF9, 32'd6, -1, bn, dn, da);
    chk("mul_busy_cycles", bn, W);
    chk("mul_done_count", dn, 1);
    chk("mul_done_at", da, W);
    chk("mul_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mul_lo", bus.lo, 32'hFFFF_FFD6);

    // Divide -17 / 5, then most-negative / -1
    run_op(0, 1, 32'hFFFF_FFEF, 32'd5, -1, bn, dn, da);
    chk("div_lo", bus.lo, 32'hFFFF_FFFD);
    chk("div_hi", bus.hi, 32'hFFFF_FFFE);
    chk("div_dz", {31'd0, bus.divZero}, 32'h0);
    chk("div_done_at", da, W);
    run_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, -1, bn, dn, da);
    chk("divovf_lo", bus.lo, 32'h8000_0000);
    chk("divovf_hi", bus.hi, 32'h0);

    // Preload, then divide by zero
    run_op(1, 0, 32'd2, 32'h8000_0000, -1, bn, dn, da);
    chk("pre_hi", bus.hi, 32'hFFFF_FFFF);
    chk("pre_lo", bus.lo, 32'h0);
    run_op(0, 1, 32'd77, 32'd0, -1, bn, dn, da);
    chk("dz_done_at", da, 0);
    chk("dz_busy", bn, 0);
    chk("dz_flag", {31'd0, bus.divZero}, 32'h1);
    chk("dz_hi_kept", bus.hi, 32'hFFFF_FFFF);
    chk("dz_lo_kept", bus.lo, 32'h0);

    // Both strobes: multiply wins; also clears divZero
    run_op(1, 1, 32'd3, 32'd4, -1, bn, dn, da);
    chk("prio_lo", bus.lo, 32'd12);
    chk("prio_hi", bus.hi, 32'd0);
    chk("prio_dz_clr", {31'd0, bus.divZero}, 32'h0);

    // divOp pulsed mid-multiply is ignored
    run_op(1, 0, 32'd1000, 32'hFFFF_FFFE, 5, bn, dn, da);
    chk("ign_done_count", dn, 1);
    chk("ign_lo", bus.lo, 32'hFFFF_F830);

`ifdef MULT_DIV_ZERO_SHORTCUT_EN
    run_op(1, 0, 32'd0, 32'd5, -1, bn, dn, da);
    chk("zs_done_at", da, 0);
    chk("zs_busy", bn, 0);
    chk("zs_lo", bus.lo, 32'd0);
`endif

    // Reset mid-multiply
    @(negedge clk);
    bus.multOp = 1'b1; bus.a = 32'd5; bus.b = 32'd7;
    @(negedge clk); bus.multOp = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_hi", bus.hi, 32'h0);
    chk("rst_mid_lo", bus.lo, 32'h0);
    chk("rst_mid_flags", {29'd0, bus.busy, bus.done, bus.divZero}, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    dn = 0;
    for (int i = 0; i < W + 8; i++) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    chk("rst_mid_no_done", dn, 0);

    // Random operations, checked by the cycle model
    for (int k = 0; k < 40; k++) begin
      ra = pick(); rb = pick();
      run_op($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, ra, rb,
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W - 2)) : -1, bn, dn, da);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
